// File: rtl/serial_ins_sender_if.sv
// Fetch-side bundle of the serial instruction sender: the instruction handshake
// with instruction memory, the fetch PC and the branch/jump redirect.
interface serial_ins_sender_if #(
    parameter int INS_WIDTH = 32
);
    logic [INS_WIDTH-1:0] ins_word;
    logic                 ins_valid;
    logic                 ins_ready;
    logic [31:0]          pc;
    logic                 pc_load;
    logic [31:0]          pc_target;

    modport master (
        output ins_word, ins_valid, pc_load, pc_target,
        input  ins_ready, pc
    );

    modport slave (
        input  ins_word, ins_valid, pc_load, pc_target,
        output ins_ready, pc
    );
endinterface

// File: rtl/serial_ins_sender.sv
// Serial instruction sender: one-word prefetch and LSB-first framing onto a 99-cycle link.
// Build option: define SER_SEND_NOP_FILL_EN to send the RISC-V NOP in fill frames.
module serial_ins_sender #(
    parameter int                   INS_WIDTH = 32,
    parameter int                   FRAME_LEN = 99,
    parameter int                   CNT_W     = 7,
    parameter logic [INS_WIDTH-1:0] FILL_WORD = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    serial_ins_sender_if.slave  fetch,
    output logic                ins,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                underrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SER_SEND_NOP_FILL_EN
    localparam logic [INS_WIDTH-1:0] FILL_SEL = INS_WIDTH'(32'h0000_0013);
`else
    localparam logic [INS_WIDTH-1:0] FILL_SEL = FILL_WORD;
`endif

    logic [CNT_W-1:0]     frame_cnt_r;
    logic [CNT_W-1:0]     frame_cnt_s;
    logic [INS_WIDTH-1:0] shreg_r;
    logic [INS_WIDTH-1:0] shreg_s;
    logic [INS_WIDTH-1:0] buf_word_r;
    logic [INS_WIDTH-1:0] buf_word_s;
    logic                 buf_full_r;
    logic                 buf_full_s;
    logic                 underrun_r;
    logic                 underrun_s;
    logic [31:0]          pc_r;
    logic [31:0]          pc_s;
    logic                 wrap_s;
    logic                 ready_s;
    logic                 accept_s;

    // A redirect blocks the handshake so a wrong-path word is never taken.
    assign wrap_s   = (frame_cnt_r == LAST_CNT);
    assign ready_s  = !fetch.pc_load && (!buf_full_r || wrap_s);
    assign accept_s = fetch.ins_valid && ready_s;

    assign fetch.ins_ready = ready_s;
    assign fetch.pc        = pc_r;
    assign ins             = shreg_r[0];
    assign frame_cnt       = frame_cnt_r;
    assign underrun        = underrun_r;

    // Next-state logic for frame counter, shifter, prefetch buffer and PC.
    always_comb begin
        frame_cnt_s = frame_cnt_r;
        shreg_s     = shreg_r;
        buf_word_s  = buf_word_r;
        buf_full_s  = buf_full_r;
        underrun_s  = 1'b0;
        pc_s        = pc_r;

        if (fetch.pc_load) begin
            pc_s = fetch.pc_target;
        end else if (accept_s) begin
            pc_s = pc_r + 32'd4;
        end else begin
            pc_s = pc_r;
        end

        if (wrap_s) begin
            frame_cnt_s = {CNT_W{1'b0}};
            if (fetch.pc_load) begin
                shreg_s    = FILL_SEL;
                buf_full_s = 1'b0;
                underrun_s = 1'b1;
            end else if (buf_full_r) begin
                // Drain the buffer; a same-edge accept refills it.
                shreg_s    = buf_word_r;
                buf_full_s = accept_s;
                if (accept_s) begin
                    buf_word_s = fetch.ins_word;
                end else begin
                    buf_word_s = buf_word_r;
                end
            end else if (accept_s) begin
                shreg_s    = fetch.ins_word;
                buf_full_s = 1'b0;
            end else begin
                shreg_s    = FILL_SEL;
                buf_full_s = 1'b0;
                underrun_s = 1'b1;
            end
        end else begin
            frame_cnt_s = frame_cnt_r + CNT_ONE;
            // Shifting zeros in keeps ins low once all word bits have left.
            shreg_s     = {1'b0, shreg_r[INS_WIDTH-1:1]};
            if (fetch.pc_load) begin
                buf_full_s = 1'b0;
            end else if (accept_s) begin
                buf_full_s = 1'b1;
                buf_word_s = fetch.ins_word;
            end else begin
                buf_full_s = buf_full_r;
            end
        end
    end

    // State registers with asynchronous reset to the idle fill frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            shreg_r     <= FILL_SEL;
            buf_word_r  <= {INS_WIDTH{1'b0}};
            buf_full_r  <= 1'b0;
            underrun_r  <= 1'b0;
            pc_r        <= 32'h0000_0000;
        end else begin
            frame_cnt_r <= frame_cnt_s;
            shreg_r     <= shreg_s;
            buf_word_r  <= buf_word_s;
            buf_full_r  <= buf_full_s;
            underrun_r  <= underrun_s;
            pc_r        <= pc_s;
        end
    end

endmodule

// File: tb/tb_serial_ins_sender.sv
// Self-checking bench for serial_ins_sender: a receiver model reassembles each frame
// and compares it against words queued when the stimulus was driven.
module tb_serial_ins_sender;

    logic       clk;
    logic       reset;
    logic       ins;
    logic [6:0] frame_cnt;
    logic       underrun;

    logic [6:0]  rx_cnt;
    logic [31:0] rx_buf;
    int          stray_cnt;
    int          errors;
    int          checks;
    logic [31:0] fill_w;
    logic [31:0] exp_q[$];

    localparam logic [31:0] W_ADD = 32'h0020_81B3;
    localparam logic [31:0] W_A   = 32'h4020_81B3;
    localparam logic [31:0] W_B   = 32'h0031_0233;
    localparam logic [31:0] W_V   = 32'h00A5_5A13;

    serial_ins_sender_if #(.INS_WIDTH(32)) fif ();

    serial_ins_sender dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fif),
        .ins       (ins),
        .frame_cnt (frame_cnt),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver phase counter, released from reset together with the sender.
    always @(posedge clk or negedge reset) begin
        if (!reset) rx_cnt <= 7'd0;
        else if (rx_cnt == 7'd98) rx_cnt <= 7'd0;
        else rx_cnt <= rx_cnt + 7'd1;
    end

    // Receiver shift-in of bits 0..31 and counting of stray ones after the word.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_cnt < 7'd32) rx_buf[rx_cnt[4:0]] <= ins;
            else if (ins !== 1'b0) stray_cnt <= stray_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic wait_cnt(input int k);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            @(negedge clk);
            if (frame_cnt == 7'(k)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt: frame_cnt=%0d never reached required %0d", frame_cnt, k);
        end
    endtask

    task automatic do_reset(input logic valid, input logic [31:0] word);
        @(negedge clk);
        fif.ins_valid = valid;
        fif.ins_word  = word;
        fif.pc_load   = 1'b0;
        fif.pc_target = 32'h0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        fif.ins_valid = 1'b0;
        fif.ins_word  = 32'h0;
        fif.pc_load   = 1'b0;
        fif.pc_target = 32'h0;
        #12;
        checks++; if (frame_cnt !== 7'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", frame_cnt); end
        checks++; if (fif.pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", fif.pc); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b exp 0", underrun); end
        checks++; if (ins !== fill_w[0]) begin errors++; $display("FAIL rst_ins: got %b exp %b", ins, fill_w[0]); end
        checks++; if (fif.ins_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", fif.ins_ready); end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (frame_cnt !== 7'd5 || rx_cnt !== 7'd5) begin errors++; $display("FAIL rst_count: got %0d/%0d exp 5", frame_cnt, rx_cnt); end
    endtask

    task automatic test_first_word;
        logic [31:0] exp;
        int stray0;
        stray0 = stray_cnt;
        do_reset(1'b1, W_ADD);
        exp_q.push_back(fill_w);
        exp_q.push_back(W_ADD);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL first_nopulse: got %b exp 0", underrun); end
        @(negedge clk);
        checks++; if (fif.pc !== 32'h4) begin errors++; $display("FAIL first_pc: got %h exp 4", fif.pc); end
        checks++; if (fif.ins_ready !== 1'b0) begin errors++; $display("FAIL first_ready: got %b exp 0", fif.ins_ready); end
        for (int f = 0; f < 2; f++) begin
            wait_cnt(32);
            exp = exp_q.pop_front();
            checks++; if (rx_buf !== exp) begin errors++; $display("FAIL first_frame%0d: got %h exp %h", f, rx_buf, exp); end
        end
        checks++; if (stray_cnt !== stray0) begin errors++; $display("FAIL first_tail: %0d stray ones, exp 0", stray_cnt - stray0); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        do_reset(1'b1, W_A);
        exp_q.push_back(fill_w);
        exp_q.push_back(W_A);
        exp_q.push_back(W_B);
        @(negedge clk);
        fif.ins_word = W_B;
        checks++; if (fif.pc !== 32'h4) begin errors++; $display("FAIL b2b_pc4: got %h exp 4", fif.pc); end
        checks++; if (fif.ins_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready1: got %b exp 0", fif.ins_ready); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL b2b_fill: got %h exp %h", rx_buf, exp); end
        wait_cnt(50);
        checks++; if (fif.ins_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready50: got %b exp 0", fif.ins_ready); end
        wait_cnt(98);
        checks++; if (fif.ins_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready98: got %b exp 1", fif.ins_ready); end
        @(negedge clk);
        fif.ins_valid = 1'b0;
        checks++; if (fif.pc !== 32'h8) begin errors++; $display("FAIL b2b_pc8: got %h exp 8", fif.pc); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_under_a: got %b exp 0", underrun); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL b2b_word_a: got %h exp %h", rx_buf, exp); end
        wait_cnt(50);
        checks++; if (fif.ins_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_b: got %b exp 0", fif.ins_ready); end
        wait_cnt(98);
        @(negedge clk);
        checks++; if (underrun !== 1'b0 || fif.pc !== 32'h8) begin errors++; $display("FAIL b2b_frame_b: got under=%b pc=%h exp 0/8", underrun, fif.pc); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL b2b_word_b: got %h exp %h", rx_buf, exp); end
    endtask

    task automatic test_underrun;
        logic [31:0] exp;
        do_reset(1'b0, 32'h0);
        exp_q.push_back(fill_w);
        exp_q.push_back(fill_w);
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL und_first: got %h exp %h", rx_buf, exp); end
        wait_cnt(98);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_pre: got %b exp 0", underrun); end
        @(negedge clk);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_pulse: got %b exp 1", underrun); end
        @(negedge clk);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_post: got %b exp 0", underrun); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL und_fill: got %h exp %h", rx_buf, exp); end
        checks++; if (fif.pc !== 32'h0) begin errors++; $display("FAIL und_pc: got %h exp 0", fif.pc); end
    endtask

    task automatic test_pc_load;
        logic [31:0] exp;
        do_reset(1'b1, W_ADD);
        exp_q.push_back(fill_w);
        @(negedge clk);
        fif.ins_valid = 1'b0;
        checks++; if (fif.pc !== 32'h4) begin errors++; $display("FAIL pcl_pc4: got %h exp 4", fif.pc); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL pcl_fill1: got %h exp %h", rx_buf, exp); end
        wait_cnt(50);
        fif.pc_load   = 1'b1;
        fif.pc_target = 32'h0000_0100;
        fif.ins_valid = 1'b1;
        fif.ins_word  = W_B;
        #1;
        checks++; if (fif.ins_ready !== 1'b0) begin errors++; $display("FAIL pcl_ready: got %b exp 0", fif.ins_ready); end
        @(negedge clk);
        fif.pc_load   = 1'b0;
        fif.ins_valid = 1'b0;
        checks++; if (fif.pc !== 32'h100) begin errors++; $display("FAIL pcl_pc100: got %h exp 100", fif.pc); end
        wait_cnt(98);
        @(negedge clk);
        exp_q.push_back(fill_w);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL pcl_drop: got %b exp 1", underrun); end
        wait_cnt(10);
        fif.ins_valid = 1'b1;
        fif.ins_word  = W_A;
        @(negedge clk);
        fif.ins_valid = 1'b0;
        checks++; if (fif.pc !== 32'h104) begin errors++; $display("FAIL pcl_pc104: got %h exp 104", fif.pc); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL pcl_fill2: got %h exp %h", rx_buf, exp); end
        wait_cnt(98);
        fif.pc_load   = 1'b1;
        fif.pc_target = 32'h0000_0200;
        exp_q.push_back(fill_w);
        @(negedge clk);
        fif.pc_load = 1'b0;
        checks++; if (underrun !== 1'b1 || fif.pc !== 32'h200) begin errors++; $display("FAIL pcl_wrap: got under=%b pc=%h exp 1/200", underrun, fif.pc); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL pcl_fill3: got %h exp %h", rx_buf, exp); end
    endtask

    task automatic test_bypass;
        logic [31:0] exp;
        do_reset(1'b0, 32'h0);
        exp_q.push_back(fill_w);
        wait_cnt(10);
        fif.pc_load   = 1'b1;
        fif.pc_target = 32'hFFFF_FFFC;
        @(negedge clk);
        fif.pc_load = 1'b0;
        checks++; if (fif.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL byp_pcset: got %h exp fffffffc", fif.pc); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL byp_fill: got %h exp %h", rx_buf, exp); end
        wait_cnt(98);
        checks++; if (fif.ins_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %b exp 1", fif.ins_ready); end
        fif.ins_valid = 1'b1;
        fif.ins_word  = W_V;
        exp_q.push_back(W_V);
        @(negedge clk);
        fif.ins_valid = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL byp_under: got %b exp 0", underrun); end
        checks++; if (fif.pc !== 32'h0) begin errors++; $display("FAIL byp_pcwrap: got %h exp 0", fif.pc); end
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL byp_word: got %h exp %h", rx_buf, exp); end
        wait_cnt(98);
        @(negedge clk);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL byp_empty: got %b exp 1", underrun); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] exp;
        do_reset(1'b1, W_ADD);
        exp_q.push_back(fill_w);
        @(negedge clk);
        fif.ins_valid = 1'b0;
        wait_cnt(32);
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL mid_fill: got %h exp %h", rx_buf, exp); end
        wait_cnt(17);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (frame_cnt !== 7'd0 || fif.pc !== 32'h0) begin errors++; $display("FAIL mid_async: got cnt=%0d pc=%h exp 0/0", frame_cnt, fif.pc); end
        checks++; if (ins !== fill_w[0] || underrun !== 1'b0 || fif.ins_ready !== 1'b1) begin errors++; $display("FAIL mid_outs: got ins=%b under=%b rdy=%b exp %b/0/1", ins, underrun, fif.ins_ready, fill_w[0]); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        checks++; if (frame_cnt !== 7'd0 || rx_cnt !== 7'd0) begin errors++; $display("FAIL mid_release: got %0d/%0d exp 0", frame_cnt, rx_cnt); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_nopulse: got %b exp 0", underrun); end
        exp_q.push_back(fill_w);
        wait_cnt(32);
        checks++; if (rx_cnt !== 7'd32) begin errors++; $display("FAIL mid_lockstep: got rx %0d exp 32", rx_cnt); end
        exp = exp_q.pop_front();
        checks++; if (rx_buf !== exp) begin errors++; $display("FAIL mid_refill: got %h exp %h", rx_buf, exp); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        stray_cnt = 0;
        rx_buf    = 32'h0;
`ifdef SER_SEND_NOP_FILL_EN
        fill_w = 32'h0000_0013;
`else
        fill_w = 32'h0000_0000;
`endif
        test_reset();
        test_first_word();
        test_back_to_back();
        test_underrun();
        test_pc_load();
        test_bypass();
        test_reset_midframe();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries exp 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_ins_sender.md
Name: serial_ins_sender

Overview:
- Transmit end of the serial instruction link into the serial control unit.
- Fetches 32-bit instruction words from instruction memory through a valid/ready handshake and prefetches one word.
- Shifts each word out LSB-first on the single-bit `ins` line, aligned to the control unit's fixed 99-cycle frame.
- Owns the fetch PC, which increments per fetch and can be redirected by a branch/jump load.

Parameters:
- INS_WIDTH, 32: instruction bits shifted out per frame.
- FRAME_LEN, 99: cycles per frame; the receiver counter runs 0..98 and then wraps.
- CNT_W, 7: frame counter width; must satisfy 2^CNT_W >= FRAME_LEN.
- FILL_WORD, 32'h0000_0000: word sent when no instruction is available.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; assert with reset=0.
- ins_word  in  INS_WIDTH  instruction from instruction memory.
- ins_valid  in  1  ins_word is valid this cycle.
- ins_ready  out  1  sender accepts ins_word this cycle.
- pc  out  32  address of the next word to fetch.
- pc_load  in  1  redirect request (branch/jump taken).
- pc_target  in  32  redirect address.
- ins  out  1  serial instruction bit to the control unit.
- frame_cnt  out  CNT_W  frame position; mirrors the receiver phase counter.
- underrun  out  1  one-cycle pulse: the frame starting now carries the fill word.

Behaviour:
- Reset (reset=0, asynchronous):
  - frame_cnt=0, pc=0, buffer empty, shreg=FILL_WORD, underrun=0.
  - The first frame after reset carries the fill word and is a defined underrun, without the pulse.
- Frame counter:
  - Increments each edge; wraps from FRAME_LEN-1 to 0. The edge that ends the cycle with frame_cnt=FRAME_LEN-1 is the "wrap edge".
  - Both ends leave reset together, so frame_cnt equals the receiver counter every cycle.
- Serial output:
  - ins = shreg[0], taken straight from a register with no combinational path from inputs.
  - Bit k of the frame word is on ins during the cycle with frame_cnt=k, for k=0..INS_WIDTH-1.
  - While frame_cnt < INS_WIDTH-1, shreg shifts right each edge with a 0 shifted in.
  - ins=0 for frame_cnt >= INS_WIDTH.
- Prefetch buffer (1 entry, buf_full flag):
  - ins_ready = !buf_full OR (frame_cnt==FRAME_LEN-1); this allows accept and drain in the same cycle.
  - Handshake: ins_valid && ins_ready at an edge captures ins_word.
- At the wrap edge, shreg loads in priority order:
  - (a) the buffered word, if buf_full;
  - (b) ins_word directly (bypass), if the buffer is empty and a handshake happens this edge;
  - (c) otherwise FILL_WORD, and underrun=1 for the following cycle (frame_cnt=0).
  - buf_full is then set only if a handshake happened while the buffer was already draining (case a with a simultaneous accept).
- Off the wrap edge, a handshake sets buf_full.
- PC:
  - On each handshake, pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - pc_load=1 at an edge: pc <= pc_target, which overrides the increment.
  - pc_load also clears buf_full, discarding the prefetched wrong-path word.
  - A handshake in the same cycle as pc_load is discarded (ins_ready is forced to 0 while pc_load=1).
  - pc_load on the wrap edge: the buffer is discarded and shreg loads FILL_WORD, with an underrun pulse.
  - The frame already being shifted is never altered mid-frame.
- Reset mid-frame: everything returns to reset values immediately; the partially sent word is lost.

Optional Feature:
- Macro: SER_SEND_NOP_FILL_EN.
- Defined: fill frames carry the RISC-V NOP 32'h0000_0013 (addi x0,x0,0), overriding FILL_WORD, so the receiver executes a harmless instruction.
- Undefined: fill frames carry the FILL_WORD parameter value.
- The underrun pulse behaves identically in both builds.

Test Plan:
- Reset, then ins_valid=1 with ins_word=32'h0020_81B3 (add x3,x1,x2) held from cycle 0:
  - first frame sends the fill word with ins low for all 99 cycles;
  - frame 2 shows bits 1,1,0,0,1,1,0,1,1,0... LSB-first on ins at frame_cnt 0..31;
  - receiver insbuffer==32'h0020_81B3 at frame_cnt 32.
- Back-to-back words A=32'h4020_81B3 and B=32'h0031_0233 offered continuously:
  - A, then B, sent in consecutive frames;
  - pc goes 0→4→8;
  - ins_ready is low while the buffer is full, except at frame_cnt=98.
- ins_valid=0 across a wrap edge:
  - underrun=1 exactly at frame_cnt=0;
  - frame sends FILL_WORD, or 0x00000013 with SER_SEND_NOP_FILL_EN;
  - pc unchanged.
- Buffer holds 32'h0020_81B3; pc_load=1 with pc_target=32'h0000_0100 at frame_cnt=50:
  - pc=0x100;
  - buffered word dropped;
  - next frame underruns unless a word is accepted by frame_cnt=98.
- ins_valid asserted for the first time exactly at frame_cnt=98 with the buffer empty: bypass, and the word is sent in the next frame with no underrun.
- reset driven low at frame_cnt=17 for 3 cycles, asynchronous to clk:
  - outputs return to reset values within the same cycle;
  - after release, frame_cnt restarts at 0 in lockstep with the receiver.
